piso_ctrl: RTL and testbench
============================

PISO_CTRL -- requirements
Module: piso_ctrl

Interface
REQ-001 Parameter WIDTH, 8, word width; equals the WIDTH of the paired piso.
REQ-002 Parameter GAP, 0, idle cycles inserted after each frame (0..255).
REQ-003 Port clk  in  1  single clock; all state changes on the rising edge.
REQ-004 Port rst  in  1  asynchronous, active-high reset.
REQ-005 Port in_valid  in  1  upstream word available.
REQ-006 Port in_data  in  WIDTH  upstream word.
REQ-007 Port in_ready  out  1  controller accepts a word this cycle.
REQ-008 Port abort  in  1  synchronous abort of the current frame.
REQ-009 Port latch  out  1  load strobe to piso latch.
REQ-010 Port pdata  out  WIDTH  parallel word to piso din.
REQ-011 Port frame  out  1  high while serial data bits are valid on piso dout.
REQ-012 Port done  out  1  one-cycle pulse on the last frame cycle.
REQ-013 Port par_sel  out  1  high in the parity cycle (selects par_bit instead of dout).
REQ-014 Port par_bit  out  1  even-parity bit of the current word.

Function
REQ-015 States: IDLE, LOAD, SHIFT, PAR, GAP.
REQ-016 IDLE: in_ready=1; handshake in_valid&&in_ready registers in_data into the word register; next state is LOAD.
REQ-017 LOAD lasts exactly 1 cycle: latch=1, pdata=word; next state is SHIFT.
REQ-018 SHIFT lasts exactly WIDTH cycles: frame=1; down-counter of width $clog2(WIDTH) loads WIDTH-1 and exits at 0 without wrap.
REQ-019 The SHIFT exit goes to PAR if parity is compiled in, else GAP if GAP>0, else IDLE.
REQ-020 PAR lasts 1 cycle: par_sel=1, frame=1; par_bit = XOR-reduce of the word.
REQ-021 GAP lasts GAP cycles with all strobes low, then goes to IDLE.
REQ-022 done=1 only in the final frame cycle (last SHIFT or PAR); it is never asserted on abort.
REQ-023 in_ready=0 in all states other than IDLE; minimum word period is WIDTH+2+GAP (+1 with parity) cycles.
REQ-024 latch is high only in LOAD.
REQ-025 pdata holds the word register in all states; it does not change outside an IDLE handshake.
REQ-026 abort=1 in any non-IDLE state forces IDLE on the next edge and clears frame, latch, par_sel and done; abort in IDLE is ignored.
REQ-027 If abort and in_valid are both high in IDLE, the word is accepted.
REQ-028 in_data changes while not ready have no effect.

Reset
REQ-029 rst=1 forces immediately: state IDLE, counter 0, word 0, latch 0, frame 0, done 0, par_sel 0, par_bit 0, in_ready 0.
REQ-030 in_ready rises one clock after rst deasserts.
REQ-031 Reset mid-frame discards the word; no done is issued.

Configuration
REQ-032 Macro PISO_CTRL_PARITY_EN, when defined: PAR state present; frame extends by 1 cycle; par_sel and par_bit are driven as in REQ-020.
REQ-033 PISO_CTRL_PARITY_EN undefined: PAR state absent; par_sel and par_bit tied 0; done falls on the last SHIFT cycle.

Structure
REQ-034 Package piso_ctrl_pkg holds the state enum type and a counter-width constant function.
REQ-035 No sub-module: the counter and FSM are inline.
REQ-036 The bench instantiates piso_ctrl together with piso (latch→latch, pdata→din, ser=0).

Verification
REQ-037 WIDTH=8, parity off, GAP=0: accept 8'h55 at edge k -> latch high for cycle k+1, frame high for cycles k+2..k+9, done at k+9, piso dout alternates 0/1 over the frame, in_ready back at k+10.
REQ-038 Parity on: words 8'hcd and 8'h0f -> par_sel 1 cycle after the 8 data cycles, par_bit=1 and 0 respectively, done in the PAR cycle.
REQ-039 GAP=3, in_valid held high with 8'hAA then 8'hf0 -> second latch exactly 8+1+3+1 cycles after the first, no overlap of frame.
REQ-040 abort on the 4th SHIFT cycle of 8'h80 -> IDLE next cycle, no done, in_ready=1, next word frames normally.
REQ-041 rst asserted asynchronously mid-SHIFT -> all outputs 0 without a clock edge; after release, in_ready=1 on the next edge.
REQ-042 in_data toggled while busy -> pdata and the serial stream unchanged.

Source files
------------

// File: rtl/piso_ctrl_pkg.sv
// piso_ctrl_pkg -- shared types and helpers for the PISO frame controller.
//   state_t   : controller FSM states (IDLE, LOAD, SHIFT, PAR, GAP)
//   cnt_width : width of the shift down-counter for a given word width
//   GAP_CNT_W : width of the inter-frame idle counter (GAP range 0..255)
package piso_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_PAR   = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int GAP_CNT_W = 8;

  // A one-bit word still needs a one-bit counter.
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/piso_ctrl_if.sv
// piso_ctrl_if -- bundle between the word source, the controller and the piso.
//   Upstream side : in_valid, in_data (source -> ctrl), in_ready (ctrl -> source),
//                   abort (source -> ctrl)
//   Piso side     : latch, pdata, frame, done, par_sel, par_bit (ctrl -> piso/sink)
//   Debug         : state (current controller FSM state)
// Modports: slave = controller view, master = source/sink (bench) view.
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_valid may be asserted regardless of in_ready;
// in_data must be stable while in_valid is high and in_ready is low only if
// the source cares which word is taken -- the controller samples in_data
// solely on the transfer edge.
interface piso_ctrl_if #(
  parameter int WIDTH = 8
);
  import piso_ctrl_pkg::*;

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             abort;
  logic             latch;
  logic [WIDTH-1:0] pdata;
  logic             frame;
  logic             done;
  logic             par_sel;
  logic             par_bit;
  state_t           state;

  modport slave (
    input  in_valid, in_data, abort,
    output in_ready, latch, pdata, frame, done, par_sel, par_bit, state
  );

  modport master (
    output in_valid, in_data, abort,
    input  in_ready, latch, pdata, frame, done, par_sel, par_bit, state
  );

endinterface

// File: rtl/piso.sv
// piso -- parallel-in / serial-out shift register paired with piso_ctrl.
//   clk, rst : clock, asynchronous active-high reset
//   latch    : load din into the shift register on the next edge
//   din      : parallel word
//   ser      : bit shifted in at the LSB end
//   dout     : serial output, MSB first
module piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             latch,
  input  logic [WIDTH-1:0] din,
  input  logic             ser,
  output logic             dout
);

  logic [WIDTH-1:0] sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg <= '0;
    end else if (latch) begin
      sreg <= din;
    end else begin
      sreg <= {sreg[WIDTH-2:0], ser};
    end
  end

  assign dout = sreg[WIDTH-1];

endmodule

// File: rtl/piso_ctrl.sv
// piso_ctrl -- frame controller driving a piso shift register.
// Accepts one word in IDLE, strobes latch for one cycle (LOAD), marks WIDTH
// serial cycles with frame (SHIFT), optionally a parity cycle (PAR), then
// GAP idle cycles before accepting the next word.
//   Parameters : WIDTH (word width), GAP (idle cycles after a frame, 0..255)
//   Ports      : clk, rst (async active-high), bus (piso_ctrl_if.slave)
//   Macro      : PISO_CTRL_PARITY_EN -- when defined, adds the PAR cycle with
//                even parity on par_bit; otherwise par_sel/par_bit are 0.
module piso_ctrl
  import piso_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 0
) (
  input  logic        clk,
  input  logic        rst,
  piso_ctrl_if.slave  bus
);

  localparam int                   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0]        CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'(GAP - 1);

  state_t               state, state_nx;
  logic [CW-1:0]        cnt, cnt_nx;
  logic [GAP_CNT_W-1:0] gcnt, gcnt_nx;
  logic [WIDTH-1:0]     word;
  logic                 rdy_en;
  logic                 handshake;
  logic                 last_cycle;

  // rdy_en keeps in_ready low during reset and for the first edge after it.
  assign bus.in_ready = rdy_en && (state == S_IDLE);
  assign handshake    = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      gcnt   <= '0;
      word   <= '0;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      gcnt   <= gcnt_nx;
      rdy_en <= 1'b1;
      if (handshake) begin
        word <= bus.in_data;
      end
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gcnt_nx  = gcnt;
    case (state)
      S_IDLE: begin
        if (handshake) begin
          state_nx = S_LOAD;
        end
      end
      S_LOAD: begin
        state_nx = S_SHIFT;
        cnt_nx   = CNT_LAST;
      end
      S_SHIFT: begin
        // Counter holds at zero on exit rather than wrapping.
        if (cnt == '0) begin
`ifdef PISO_CTRL_PARITY_EN
          state_nx = S_PAR;
`else
          if (GAP > 0) begin
            state_nx = S_GAP;
            gcnt_nx  = GAP_LAST;
          end else begin
            state_nx = S_IDLE;
          end
`endif
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
`ifdef PISO_CTRL_PARITY_EN
      S_PAR: begin
        if (GAP > 0) begin
          state_nx = S_GAP;
          gcnt_nx  = GAP_LAST;
        end else begin
          state_nx = S_IDLE;
        end
      end
`endif
      S_GAP: begin
        if (gcnt == '0) begin
          state_nx = S_IDLE;
        end else begin
          gcnt_nx = gcnt - 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    // Abort wins over every transition out of a busy state; in IDLE it is
    // ignored so a simultaneous in_valid is still accepted.
    if (bus.abort && (state != S_IDLE)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      gcnt_nx  = '0;
    end
  end

`ifdef PISO_CTRL_PARITY_EN
  assign last_cycle  = (state == S_PAR);
  assign bus.par_sel = (state == S_PAR);
  assign bus.par_bit = ^word;
`else
  assign last_cycle  = (state == S_SHIFT) && (cnt == '0);
  assign bus.par_sel = 1'b0;
  assign bus.par_bit = 1'b0;
`endif

  assign bus.latch = (state == S_LOAD);
  assign bus.pdata = word;
  assign bus.frame = (state == S_SHIFT) || (state == S_PAR);
  // An aborted final cycle must not look like a completed frame.
  assign bus.done  = last_cycle && !bus.abort;
  assign bus.state = state;

endmodule

// File: tb/tb_piso_ctrl.sv
// tb_piso_ctrl -- directed bench for piso_ctrl paired with piso.
// Two controller/piso pairs: GAP=0 (main sequence) and GAP=3 (back-to-back).
// The serial line seen downstream (dout, or par_bit in the parity cycle) is
// checked against bits queued when each word is handed over.
module tb_piso_ctrl;
  import piso_ctrl_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic dout0, dout3;

  always #5 clk = ~clk;

  piso_ctrl_if #(.WIDTH(W)) b0 ();
  piso_ctrl_if #(.WIDTH(W)) b3 ();

  piso_ctrl #(.WIDTH(W), .GAP(0)) u_ctrl0 (.clk(clk), .rst(rst), .bus(b0));
  piso #(.WIDTH(W)) u_piso0 (
    .clk(clk), .rst(rst), .latch(b0.latch), .din(b0.pdata), .ser(1'b0), .dout(dout0)
  );

  piso_ctrl #(.WIDTH(W), .GAP(3)) u_ctrl3 (.clk(clk), .rst(rst), .bus(b3));
  piso #(.WIDTH(W)) u_piso3 (
    .clk(clk), .rst(rst), .latch(b3.latch), .din(b3.pdata), .ser(1'b0), .dout(dout3)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp0_q[$];
  logic exp3_q[$];

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // Expected serial bits for one word: MSB first, then parity when built in.
  function automatic void push_bits(input int id, input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) begin
      if (id == 0) exp0_q.push_back(w[i]);
      else         exp3_q.push_back(w[i]);
    end
`ifdef PISO_CTRL_PARITY_EN
    if (id == 0) exp0_q.push_back(^w);
    else         exp3_q.push_back(^w);
`endif
  endfunction

  // Scoreboard: pop/compare on every frame cycle, push on a pending transfer.
  always @(negedge clk) begin
    logic e;
    if (rst === 1'b0) begin
      if (b0.frame) begin
        chk("q0_has_bit", 32'(exp0_q.size() != 0), 32'd1);
        if (exp0_q.size() != 0) begin
          e = exp0_q.pop_front();
          chk("ser0", b0.par_sel ? b0.par_bit : dout0, e);
        end
      end
      if (b3.frame) begin
        chk("q3_has_bit", 32'(exp3_q.size() != 0), 32'd1);
        if (exp3_q.size() != 0) begin
          e = exp3_q.pop_front();
          chk("ser3", b3.par_sel ? b3.par_bit : dout3, e);
        end
      end
      if (b0.in_valid && b0.in_ready) push_bits(0, b0.in_data);
      if (b3.in_valid && b3.in_ready) push_bits(3, b3.in_data);
    end
  end

  // Called at posedge+1; returns at posedge+1 of the LOAD cycle.
  task automatic send0(input logic [W-1:0] w);
    int t;
    t = 0;
    b0.in_valid = 1'b1;
    b0.in_data  = w;
    do begin
      @(negedge clk);
      t++;
    end while (!b0.in_ready && t < 50);
    chk("send0_ready", b0.in_ready, 1);
    @(posedge clk); #1;
    b0.in_valid = 1'b0;
  endtask

  // Checks LOAD, SHIFT (optional abort at shift cycle abort_at), PAR, return
  // to IDLE. Called at posedge+1 of the LOAD cycle, returns at posedge+1.
  task automatic body0(input logic [W-1:0] w, input int abort_at);
    logic ed;
    @(negedge clk);
    chk("load_latch", b0.latch, 1);
    chk("load_pdata", b0.pdata, w);
    chk("load_frame", b0.frame, 0);
    chk("load_ready", b0.in_ready, 0);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      b0.in_data = W'($urandom_range(0, 255));
      if (i == abort_at) b0.abort = 1'b1;
      @(negedge clk);
`ifdef PISO_CTRL_PARITY_EN
      ed = 1'b0;
`else
      ed = (i == W) && (abort_at != i);
      chk("shift_parbit", b0.par_bit, 0);
`endif
      chk("shift_frame", b0.frame, 1);
      chk("shift_latch", b0.latch, 0);
      chk("shift_pdata", b0.pdata, w);
      chk("shift_done", b0.done, ed);
      chk("shift_ready", b0.in_ready, 0);
      chk("shift_parsel", b0.par_sel, 0);
      if (i == abort_at) begin
        @(posedge clk); #1;
        b0.abort = 1'b0;
        exp0_q.delete();
        @(negedge clk);
        chk("abort_frame", b0.frame, 0);
        chk("abort_done", b0.done, 0);
        chk("abort_ready", b0.in_ready, 1);
        chk("abort_state", b0.state, S_IDLE);
        @(posedge clk); #1;
        return;
      end
    end
`ifdef PISO_CTRL_PARITY_EN
    @(posedge clk); #1;
    @(negedge clk);
    chk("par_sel", b0.par_sel, 1);
    chk("par_frame", b0.frame, 1);
    chk("par_done", b0.done, 1);
    chk("par_bit", b0.par_bit, ^w);
`endif
    @(posedge clk); #1;
    @(negedge clk);
    chk("end_frame", b0.frame, 0);
    chk("end_done", b0.done, 0);
    chk("end_ready", b0.in_ready, 1);
    chk("end_parsel", b0.par_sel, 0);
    chk("q0_drained", 32'(exp0_q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic frame0(input logic [W-1:0] w, input int abort_at);
    send0(w);
    body0(w, abort_at);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int first, second, ovl, c;
    rst = 1'b1;
    b0.in_valid = 1'b0; b0.in_data = '0; b0.abort = 1'b0;
    b3.in_valid = 1'b0; b3.in_data = '0; b3.abort = 1'b0;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", b0.in_ready, 0);
    chk("rst_latch", b0.latch, 0);
    chk("rst_frame", b0.frame, 0);
    chk("rst_done", b0.done, 0);
    chk("rst_parsel", b0.par_sel, 0);
    chk("rst_parbit", b0.par_bit, 0);
    chk("rst_pdata", b0.pdata, 0);
    chk("rst_state", b0.state, S_IDLE);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rel_ready_early", b0.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rel_ready", b0.in_ready, 1);
    @(posedge clk); #1;

    // Basic frames, including the parity reference words
    frame0(8'h55, 0);
    frame0(8'hcd, 0);
    frame0(8'h0f, 0);

    // Abort on the 4th shift cycle, then a normal frame
    frame0(8'h80, 4);
    frame0(8'h3c, 0);
    // Abort in the last shift cycle must suppress done
    frame0(8'h81, W);

    // Abort in IDLE is ignored and a concurrent word is accepted
    b0.abort = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_idle_ready", b0.in_ready, 1);
    @(posedge clk); #1;
    send0(8'ha5);
    b0.abort = 1'b0;
    body0(8'ha5, 0);

    // A few random words
    for (int k = 0; k < 3; k++) begin
      frame0(W'($urandom_range(0, 255)), 0);
    end

    // Asynchronous reset mid-shift
    send0(8'h96);
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_frame", b0.frame, 0);
    chk("arst_latch", b0.latch, 0);
    chk("arst_done", b0.done, 0);
    chk("arst_ready", b0.in_ready, 0);
    chk("arst_pdata", b0.pdata, 0);
    chk("arst_parbit", b0.par_bit, 0);
    chk("arst_dout", dout0, 0);
    exp0_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("arel_ready_early", b0.in_ready, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("arel_ready", b0.in_ready, 1);
    chk("arel_frame", b0.frame, 0);
    @(posedge clk); #1;
    frame0(8'h69, 0);

    // GAP=3 with in_valid held: latch-to-latch spacing
    b3.in_valid = 1'b1;
    b3.in_data  = 8'haa;
    first = -1; second = -1; ovl = 0;
    for (c = 0; c < 80 && second < 0; c++) begin
      @(negedge clk);
      if (b3.latch && b3.frame) ovl++;
      if (b3.latch) begin
        if (first < 0) first = c;
        else           second = c;
      end
      @(posedge clk); #1;
      if (first >= 0) b3.in_data = 8'hf0;
    end
    b3.in_valid = 1'b0;
    chk("gap_second_latch", 32'(second >= 0), 1);
`ifdef PISO_CTRL_PARITY_EN
    chk("gap_period", 32'(second - first), W + 1 + 3 + 1 + 1);
`else
    chk("gap_period", 32'(second - first), W + 1 + 3 + 1);
`endif
    chk("gap_overlap", 32'(ovl), 0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while ((b3.frame || !b3.in_ready) && c < 40);
    chk("gap_idle", b3.in_ready, 1);
    chk("q3_drained", 32'(exp3_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
